multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of cycles mem_req may stay high without mem_ready (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port opcode, input, 7 bits: instruction[6:0] from the instruction decoder.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory has completed the current access this cycle.
REQ-006 SHALL have port branch_taken, input, 1 bit: ALU compare result, valid in EXEC.
REQ-007 SHALL have port ir_write, output, 1 bit: load the instruction register.
REQ-008 SHALL have port pc_write, output, 1 bit: load the PC.
REQ-009 SHALL have port pc_src, output, 2 bits: PC source; 0=PC+4, 1=branch target, 2=JAL target.
REQ-010 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-011 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-012 SHALL have port mem_addr_sel, output, 1 bit: memory address source; 0=PC, 1=ALU result.
REQ-013 SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-014 SHALL have port wb_sel, output, 2 bits: writeback source; 0=ALU, 1=memory data, 2=PC+4.
REQ-015 SHALL have port alu_op, output, 2 bits: ALU operation; 0=add, 1=compare, 2=funct-decoded.
REQ-016 SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-017 SHALL have port illegal, output, 1 bit: sticky flag for an unsupported opcode.
REQ-018 SHALL have port bus_error, output, 1 bit: sticky flag for a memory timeout.
REQ-019 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-020 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to TRAP with illegal=1.
REQ-021 SHALL support these opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111.
REQ-022 In FETCH, SHALL drive mem_req=1, mem_addr_sel=0, mem_we=0; on mem_ready, SHALL pulse ir_write=1 and pc_write=1 with pc_src=0 in the same cycle, then go to DECODE; otherwise SHALL hold in FETCH.
REQ-023 In DECODE (one cycle), SHALL latch opcode into an internal register used by all later states; an unsupported opcode SHALL go to TRAP with illegal=1; otherwise SHALL go to EXEC.
REQ-024 In EXEC (one cycle): R and I-ALU SHALL use alu_op=2 and go to WB; LOAD and STORE SHALL use alu_op=0 and go to MEM; JAL SHALL pulse pc_write with pc_src=2 and go to WB.
REQ-025 In EXEC for BRANCH, SHALL use alu_op=1, pulse pc_write with pc_src=1 only if branch_taken=1, pulse retire, and go to FETCH.
REQ-026 In MEM, SHALL drive mem_req=1, mem_addr_sel=1, and mem_we=1 only for STORE; on mem_ready, STORE SHALL pulse retire and go to FETCH, and LOAD SHALL go to WB.
REQ-027 In WB (one cycle), SHALL pulse reg_write=1 and retire=1 with wb_sel=1 for LOAD, 2 for JAL, 0 otherwise, then go to FETCH.
REQ-028 In TRAP, SHALL keep all control outputs at 0 and illegal/bus_error held, and SHALL stay in TRAP until rst.
REQ-029 The timeout counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 and mem_ready=0; when it reaches MEM_TIMEOUT-1 with mem_ready=0, SHALL go to TRAP with bus_error=1.
REQ-030 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win and the normal transition SHALL be taken.
REQ-031 mem_ready outside FETCH/MEM SHALL be ignored; branch_taken outside EXEC SHALL be ignored.
REQ-032 Cycles per instruction with zero-wait memory SHALL be: R/I/JAL/STORE 4, LOAD 5, BRANCH 3; each wait cycle SHALL add 1.
REQ-033 Outputs other than state SHALL be combinational from state, latched opcode, mem_ready and branch_taken; pc_write, ir_write, reg_write and retire SHALL never be high for more than one cycle per instruction.

Reset
REQ-034 On rst=1 at a clock edge, SHALL set state=FETCH, timeout counter=0, latched opcode=0, illegal=0, bus_error=0.
REQ-035 While rst=1, SHALL force all outputs to 0 (state reads 0).
REQ-036 Reset asserted mid-instruction (including during a pending mem_req) SHALL abort without any pc_write, reg_write or retire; the first mem_req SHALL appear in the first cycle with rst=0.

Verification
REQ-037 R-type 0110011 with mem_ready tied 1 -> states 0,1,2,4; reg_write and retire in cycle 4 with wb_sel=0; mem_req next cycle.
REQ-038 LOAD with MEM-phase mem_ready delayed 3 cycles -> 8 cycles total; mem_we=0 and mem_addr_sel=1 throughout MEM; wb_sel=1 in WB.
REQ-039 BRANCH with branch_taken=1, then with 0 -> pc_write/pc_src=1 only in the first case; retire in EXEC both times; 3 cycles each.
REQ-040 Opcode 1111111 -> TRAP after DECODE with illegal=1 and no further mem_req; rst then restores FETCH with illegal=0.
REQ-041 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 request cycles; repeat with mem_ready in the 4th cycle -> DECODE, no error.
REQ-042 rst pulsed during a STORE's MEM wait -> no retire or reg_write; FETCH with mem_addr_sel=0 on the first cycle after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB with a TRAP sink.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: holds in FETCH/MEM until mem_ready; traps after MEM_TIMEOUT request cycles.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Last legal wait count; a request cycle seen at this count without ready is the timeout.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic [7:0] tmo_q, tmo_d;
  logic       illegal_q, illegal_d;
  logic       bus_error_q, bus_error_d;
  logic       mem_wait;
  logic       tmo_hit;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

  // Next-state, opcode latch, sticky error flags and memory timeout counter.
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    tmo_hit     = mem_wait && (tmo_q == TMO_LAST);

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (op_supported(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_BRANCH:         state_d = S_FETCH;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // mem_ready is checked first so a same-cycle timeout loses to completion.
        if (mem_ready) begin
          state_d = (opc_q == OP_STORE) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end
    endcase

    // Any state change restarts the count, which covers every entry into FETCH or MEM.
    if (state_d != state_q) begin
      tmo_d = 8'd0;
    end else if (mem_wait) begin
      tmo_d = tmo_q + 8'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opc_q       <= 7'd0;
      tmo_q       <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      tmo_q       <= tmo_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Datapath controls decoded from state, latched opcode and the live handshake inputs.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_op       = 2'd0;
    retire       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          case (opc_q)
            OP_R, OP_I: alu_op = 2'd2;
            OP_BRANCH: begin
              alu_op = 2'd1;
              retire = 1'b1;
              if (branch_taken) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end
            OP_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            default: alu_op = 2'd0;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opc_q == OP_STORE);
          retire       = mem_ready && (opc_q == OP_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          case (opc_q)
            OP_LOAD: wb_sel = 2'd1;
            OP_JAL:  wb_sel = 2'd2;
            default: wb_sel = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state     = rst ? 3'd0 : state_q;
  assign illegal   = !rst && illegal_q;
  assign bus_error = !rst && bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed sequences plus randomized traffic
// checked every cycle against an instruction-level reference model and a CPI formula.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_multicycle_control;
  localparam int TMO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       ir_write, pc_write, mem_req, mem_we, mem_addr_sel, reg_write, retire;
  logic       illegal, bus_error;
  logic [1:0] pc_src, wb_sel, alu_op;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  logic [6:0] ops [6] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_op(alu_op), .retire(retire), .illegal(illegal),
    .bus_error(bus_error), .state(state)
  );

  initial forever #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel,
                    reg_write, wb_sel, alu_op, retire, illegal, bus_error, state};

  function automatic logic [17:0] ev(input logic [2:0] st, input logic ir, pcw,
                                     input logic [1:0] pcs, input logic mrq, mwe, mas, rw,
                                     input logic [1:0] wb, alu, input logic ret, ill, bus);
    return {ir, pcw, pcs, mrq, mwe, mas, rw, wb, alu, ret, ill, bus, st};
  endfunction

  function automatic int cpi_base(input logic [6:0] op);
    if (op == OP_LOAD) return 5;
    if (op == OP_BRANCH) return 3;
    return 4;
  endfunction

  function automatic logic supported(input logic [6:0] op);
    for (int k = 0; k < 6; k++) if (ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [17:0] req);
    chk(nm, 32'(dut_vec), 32'(req));
  endtask

  task automatic cyc(input logic r, rdy, bt, input logic [6:0] op);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; branch_taken = bt; opcode = op;
    @(negedge clk);
  endtask

  // Reference model: instruction phase, latched opcode, request-cycle count, sticky flags.
  int         m_ph = P_FETCH;
  logic [6:0] m_opc = 7'd0;
  int         m_req_cnt = 0;
  logic       m_ill = 1'b0, m_bus = 1'b0;
  int         n_cyc = 0, n_wait = 0;

  always @(negedge clk) begin : model
    logic [2:0] st;
    logic ir, pcw, mrq, mwe, mas, rw, ret;
    logic [1:0] pcs, wb, alu;
    st = 3'd0; ir = 0; pcw = 0; mrq = 0; mwe = 0; mas = 0; rw = 0; ret = 0;
    pcs = 2'd0; wb = 2'd0; alu = 2'd0;
    if (!rst) begin
      st = 3'(m_ph);
      if (m_ph == P_FETCH) begin
        mrq = 1; ir = mem_ready; pcw = mem_ready;
      end else if (m_ph == P_EXEC) begin
        if (m_opc == OP_R || m_opc == OP_I) alu = 2'd2;
        if (m_opc == OP_JAL) begin pcw = 1; pcs = 2'd2; end
        if (m_opc == OP_BRANCH) begin
          alu = 2'd1; ret = 1;
          if (branch_taken) begin pcw = 1; pcs = 2'd1; end
        end
      end else if (m_ph == P_MEM) begin
        mrq = 1; mas = 1; mwe = (m_opc == OP_STORE);
        ret = mem_ready && (m_opc == OP_STORE);
      end else if (m_ph == P_WB) begin
        rw = 1; ret = 1;
        wb = (m_opc == OP_LOAD) ? 2'd1 : (m_opc == OP_JAL) ? 2'd2 : 2'd0;
      end
    end
    chk("cycle", 32'(dut_vec),
        32'(ev(st, ir, pcw, pcs, mrq, mwe, mas, rw, wb, alu, ret, !rst && m_ill, !rst && m_bus)));

    // Cycles per instruction measured on the DUT against base cost plus observed waits.
    if (rst) begin
      n_cyc = 0; n_wait = 0;
    end else begin
      n_cyc++;
      if (mem_req && !mem_ready) n_wait++;
      if (retire) begin
        chk("cpi", 32'(n_cyc), 32'(cpi_base(m_opc) + n_wait));
        n_cyc = 0; n_wait = 0;
      end
    end

    // Advance the model to the next cycle.
    if (rst) begin
      m_ph = P_FETCH; m_opc = 7'd0; m_req_cnt = 0; m_ill = 0; m_bus = 0;
    end else if (m_ph == P_FETCH || m_ph == P_MEM) begin
      if (mem_ready) begin
        m_req_cnt = 0;
        if (m_ph == P_FETCH) m_ph = P_DEC;
        else m_ph = (m_opc == OP_STORE) ? P_FETCH : P_WB;
      end else if (m_req_cnt + 1 >= TMO) begin
        m_ph = P_TRAP; m_bus = 1;
      end else begin
        m_req_cnt++;
      end
    end else if (m_ph == P_DEC) begin
      m_opc = opcode;
      if (supported(opcode)) m_ph = P_EXEC;
      else begin m_ph = P_TRAP; m_ill = 1; end
    end else if (m_ph == P_EXEC) begin
      if (m_opc == OP_BRANCH) m_ph = P_FETCH;
      else if (m_opc == OP_LOAD || m_opc == OP_STORE) m_ph = P_MEM;
      else m_ph = P_WB;
    end else if (m_ph == P_WB) begin
      m_ph = P_FETCH;
    end
  end

  localparam logic [17:0] Z = 18'd0;

  initial begin
    rst = 1; mem_ready = 0; branch_taken = 0; opcode = 7'd0;
    cyc(1, 0, 0, 7'd0);         chk_v("reset_idle", Z);
    cyc(1, 1, 1, OP_R);         chk_v("reset_ready", Z);

    // R-type, zero-wait memory
    cyc(0, 1, 0, OP_R);         chk_v("r_fetch",  ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_R);         chk_v("r_decode", ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_R);         chk_v("r_exec",   ev(2, 0,0,0, 0,0,0, 0,0,2, 0,0,0));
    cyc(0, 1, 0, OP_R);         chk_v("r_wb",     ev(4, 0,0,0, 0,0,0, 1,0,0, 1,0,0));
    // LOAD with three MEM wait cycles; ready lands on the timeout cycle
    cyc(0, 1, 0, OP_R);         chk_v("ld_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_LOAD);      chk_v("ld_dec",   ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 0, 0, OP_LOAD);      chk_v("ld_exec",  ev(2, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, OP_LOAD);    chk_v("ld_mem_wait", ev(3, 0,0,0, 1,0,1, 0,0,0, 0,0,0));
    end
    cyc(0, 1, 0, OP_LOAD);      chk_v("ld_mem_rdy", ev(3, 0,0,0, 1,0,1, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_LOAD);      chk_v("ld_wb",    ev(4, 0,0,0, 0,0,0, 1,1,0, 1,0,0));
    // BRANCH taken then not taken
    cyc(0, 1, 0, OP_BRANCH);    chk_v("bt_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_BRANCH);    chk_v("bt_dec",   ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 1, OP_BRANCH);    chk_v("bt_exec",  ev(2, 0,1,1, 0,0,0, 0,0,1, 1,0,0));
    cyc(0, 1, 1, OP_BRANCH);    chk_v("bn_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 1, OP_BRANCH);    chk_v("bn_dec",   ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_BRANCH);    chk_v("bn_exec",  ev(2, 0,0,0, 0,0,0, 0,0,1, 1,0,0));
    // JAL
    cyc(0, 1, 0, OP_JAL);       chk_v("jal_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_JAL);       chk_v("jal_dec",  ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_JAL);       chk_v("jal_exec", ev(2, 0,1,2, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_JAL);       chk_v("jal_wb",   ev(4, 0,0,0, 0,0,0, 1,2,0, 1,0,0));
    // Illegal opcode, then reset recovery
    cyc(0, 1, 0, 7'h7f);        chk_v("ill_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, 7'h7f);        chk_v("ill_dec",  ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 1, 7'h7f);        chk_v("ill_trap", ev(5, 0,0,0, 0,0,0, 0,0,0, 0,1,0));
    cyc(0, 1, 1, OP_R);         chk_v("ill_hold", ev(5, 0,0,0, 0,0,0, 0,0,0, 0,1,0));
    cyc(1, 1, 0, OP_R);         chk_v("ill_rst",  Z);
    // FETCH timeout after four request cycles
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, OP_R);       chk_v("tmo_wait", ev(0, 0,0,0, 1,0,0, 0,0,0, 0,0,0));
    end
    cyc(0, 1, 0, OP_R);         chk_v("tmo_trap", ev(5, 0,0,0, 0,0,0, 0,0,0, 0,0,1));
    cyc(1, 0, 0, OP_R);         chk_v("tmo_rst",  Z);
    // Ready on the fourth request cycle wins over the timeout
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, OP_STORE);   chk_v("race_wait", ev(0, 0,0,0, 1,0,0, 0,0,0, 0,0,0));
    end
    cyc(0, 1, 0, OP_STORE);     chk_v("race_rdy", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_STORE);     chk_v("race_dec", ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    // Reset during a STORE's MEM wait
    cyc(0, 0, 0, OP_STORE);     chk_v("st_exec",  ev(2, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 0, 0, OP_STORE);     chk_v("st_mem_wait", ev(3, 0,0,0, 1,1,1, 0,0,0, 0,0,0));
    cyc(0, 0, 0, OP_STORE);     chk_v("st_mem_wait2", ev(3, 0,0,0, 1,1,1, 0,0,0, 0,0,0));
    cyc(1, 1, 0, OP_STORE);     chk_v("st_rst",   Z);
    cyc(0, 0, 0, OP_STORE);     chk_v("st_refetch", ev(0, 0,0,0, 1,0,0, 0,0,0, 0,0,0));
    // Complete STORE with zero-wait memory
    cyc(0, 1, 0, OP_STORE);     chk_v("st2_fetch", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_STORE);     chk_v("st2_dec",  ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_STORE);     chk_v("st2_exec", ev(2, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    cyc(0, 1, 0, OP_STORE);     chk_v("st2_mem",  ev(3, 0,0,0, 1,1,1, 0,0,0, 1,0,0));
    cyc(0, 1, 0, OP_R);         chk_v("st2_next", ev(0, 1,1,0, 1,0,0, 0,0,0, 0,0,0));

    // Randomized traffic; the per-cycle model process does the checking
    repeat (4000) begin
      logic r;
      logic [6:0] op;
      int k;
      r = ((state == 3'd5) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
      k = $urandom_range(0, 19);
      if (k < 18) op = ops[k % 6];
      else op = 7'($urandom);
      cyc(r, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
